// File: rtl/adder_pkg.sv
// Shared types and constants for the adder stage and its downstream consumers.
package adder_pkg;

    // Accumulator control states: gathering sums, or holding a finished batch.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } accum_state_t;

    // Width of the adder's sum output (4-bit operands plus carry).
    localparam int SUM_W_DEF = 5;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Batch counter width: covers counts 0..15.
    localparam int CNT_W = clog2(16);

endpackage

// File: rtl/adder_sum_accum.sv
// Batch accumulator behind the 4-bit adder: sums COUNT adder results into one
// total, hands it out on valid/ready, and stalls the adder while a batch waits.
module adder_sum_accum
    import adder_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_in,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             flush,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] acc_cnt,
    output logic             acc_valid,
    output logic             stall,
    output logic             ovf,
    output logic             err
);

    accum_state_t     state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [SUM_W-1:0] skid, skid_nx;
    logic             skid_vld, skid_vld_nx;
    logic             ovf_nx, err_nx;
    logic             smp;
    logic [ACC_W:0]   acc_plus;
    logic [ACC_W:0]   seed_both;

    // Wide adds keep the carry-out visible for the sticky overflow flag.
    always_comb begin
        acc_plus  = {1'b0, acc} + (ACC_W+1)'(sum_in);
        seed_both = (ACC_W+1)'(skid) + (ACC_W+1)'(sum_in);
    end

    // Next-state and datapath update for the ACCUM/HOLD controller.
    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        cnt_nx      = cnt;
        skid_nx     = skid;
        skid_vld_nx = skid_vld;
        ovf_nx      = ovf;
        err_nx      = err;
        unique case (state)
            ACCUM: begin
                if (smp) begin
                    acc_nx = acc_plus[ACC_W-1:0];
                    cnt_nx = cnt + CNT_W'(1);
                    if (acc_plus[ACC_W]) ovf_nx = 1'b1;
                end
                if (cnt_nx == CNT_W'(COUNT)) begin
                    state_nx = HOLD;
                end else if (flush && (cnt != '0 || smp)) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (acc_ready) begin
                    // Accepting the batch seeds the next one from whatever
                    // arrived during HOLD: the skid entry and/or a live sample.
                    skid_vld_nx = 1'b0;
                    state_nx    = ACCUM;
                    unique case ({skid_vld, smp})
                        2'b00: begin
                            acc_nx = '0;
                            cnt_nx = '0;
                        end
                        2'b10: begin
                            acc_nx = ACC_W'(skid);
                            cnt_nx = CNT_W'(1);
                        end
                        2'b01: begin
                            acc_nx = ACC_W'(sum_in);
                            cnt_nx = CNT_W'(1);
                        end
                        2'b11: begin
                            acc_nx = seed_both[ACC_W-1:0];
                            cnt_nx = CNT_W'(2);
                            if (seed_both[ACC_W]) ovf_nx = 1'b1;
                            if (COUNT == 2) state_nx = HOLD;
                        end
                        default: ;
                    endcase
                end else if (smp) begin
                    if (!skid_vld) begin
                        skid_nx     = sum_in;
                        skid_vld_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

    // State, accumulator, skid and sticky flags; reset discards any partial batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            skid     <= '0;
            skid_vld <= 1'b0;
            ovf      <= 1'b0;
            err      <= 1'b0;
            smp      <= 1'b0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            cnt      <= cnt_nx;
            skid     <= skid_nx;
            skid_vld <= skid_vld_nx;
            ovf      <= ovf_nx;
            err      <= err_nx;
            smp      <= en_in;
        end
    end

    // Batch output and back-pressure follow the state directly.
    always_comb begin
        acc_out   = acc;
        acc_cnt   = cnt;
        acc_valid = (state == HOLD);
        stall     = (state == HOLD);
    end

endmodule

// File: tb/tb_adder_sum_accum.sv
// Self-checking bench for adder_sum_accum: random sums against batch totals
// computed directly from the sample lists.
module tb_adder_sum_accum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_in = 1'b0;
    logic       flush = 1'b0;
    logic       acc_ready = 1'b0;
    logic [4:0] sum_in = '0;
    logic [4:0] sum_nx = '0;

    logic [7:0] acc_out;
    logic [3:0] acc_cnt;
    logic       acc_valid, stall, ovf, err;
    logic [5:0] acc_out6;
    logic [3:0] acc_cnt6;
    logic       acc_valid6, stall6, ovf6, err6;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // Stand-in for the adder: its sum appears one cycle after enable.
    always @(posedge clk) if (en_in) sum_in <= sum_nx;

    adder_sum_accum dut (
        .clk(clk), .rst_n(rst_n), .en_in(en_in), .sum_in(sum_in),
        .flush(flush), .acc_ready(acc_ready),
        .acc_out(acc_out), .acc_cnt(acc_cnt), .acc_valid(acc_valid),
        .stall(stall), .ovf(ovf), .err(err)
    );

    adder_sum_accum #(.ACC_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .en_in(en_in), .sum_in(sum_in),
        .flush(flush), .acc_ready(acc_ready),
        .acc_out(acc_out6), .acc_cnt(acc_cnt6), .acc_valid(acc_valid6),
        .stall(stall6), .ovf(ovf6), .err(err6)
    );

    task automatic do_reset();
        @(negedge clk);
        en_in = 1'b0; flush = 1'b0; acc_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input int v);
        en_in  = 1'b1;
        sum_nx = 5'(v);
        @(negedge clk);
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 8 && !acc_valid; c++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if (acc_out !== 8'd0) $display("FAIL reset_acc: got %0d want 0", acc_out); else passed++;
        total++; if (acc_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", acc_cnt); else passed++;
        total++; if (acc_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", acc_valid); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passed++;
        total++; if ({ovf, err} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {ovf, err}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_batch(input int iter);
        int v[4];
        int exp_sum;
        exp_sum = 0;
        for (int k = 0; k < 4; k++) begin
            v[k] = (iter == 0) ? 3 + 2 * k : int'($urandom_range(31));
            exp_sum += v[k];
        end
        acc_ready = 1'b1;
        for (int k = 0; k < 4; k++) issue(v[k]);
        en_in = 1'b0;
        wait_valid();
        total++; if (acc_valid !== 1'b1) $display("FAIL batch_valid: got %b want 1", acc_valid); else passed++;
        total++; if (acc_out !== 8'(exp_sum)) $display("FAIL batch_acc: got %0d want %0d", acc_out, exp_sum % 256); else passed++;
        total++; if (acc_cnt !== 4'd4) $display("FAIL batch_cnt: got %0d want 4", acc_cnt); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL batch_ovf: got %b want 0", ovf); else passed++;
        @(negedge clk);
        total++; if (acc_valid !== 1'b0) $display("FAIL batch_valid_drop: got %b want 0", acc_valid); else passed++;
    endtask

    task automatic test_flush(input int iter);
        int a, b;
        a = (iter == 0) ? 10 : int'($urandom_range(31));
        b = (iter == 0) ? 6  : int'($urandom_range(31));
        // Flush with nothing gathered must not produce a batch.
        acc_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        total++; if (acc_valid !== 1'b0) $display("FAIL flush_empty: got %b want 0", acc_valid); else passed++;
        issue(a);
        issue(b);
        en_in = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (acc_valid !== 1'b1) $display("FAIL flush_valid: got %b want 1", acc_valid); else passed++;
        total++; if (acc_out !== 8'(a + b)) $display("FAIL flush_acc: got %0d want %0d", acc_out, a + b); else passed++;
        total++; if (acc_cnt !== 4'd2) $display("FAIL flush_cnt: got %0d want 2", acc_cnt); else passed++;
        acc_ready = 1'b1;
        @(negedge clk);
        total++; if (acc_valid !== 1'b0) $display("FAIL flush_accept: got %b want 0", acc_valid); else passed++;
    endtask

    task automatic test_skid(input bit drop);
        int v[4];
        int batch, extra, extra2, tail;
        do_reset();
        acc_ready = 1'b0;
        batch = 0;
        for (int k = 0; k < 4; k++) begin
            v[k] = int'($urandom_range(31));
            batch += v[k];
        end
        extra  = int'($urandom_range(31));
        extra2 = int'($urandom_range(31));
        for (int k = 0; k < 4; k++) issue(v[k]);
        issue(extra);
        total++; if (stall !== 1'b1) $display("FAIL skid_stall: got %b want 1", stall); else passed++;
        if (drop) issue(extra2);
        en_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++; if (acc_out !== 8'(batch) || acc_valid !== 1'b1)
                $display("FAIL skid_hold: got %0d/%b want %0d/1", acc_out, acc_valid, batch);
            else passed++;
            @(negedge clk);
        end
        total++; if (err !== drop) $display("FAIL skid_err: got %b want %b", err, drop); else passed++;
        acc_ready = 1'b1;
        @(negedge clk);
        total++; if (acc_valid !== 1'b0) $display("FAIL skid_accept: got %b want 0", acc_valid); else passed++;
        total++; if (acc_out !== 8'(extra)) $display("FAIL skid_seed_acc: got %0d want %0d", acc_out, extra); else passed++;
        total++; if (acc_cnt !== 4'd1) $display("FAIL skid_seed_cnt: got %0d want 1", acc_cnt); else passed++;
        tail = extra;
        for (int k = 0; k < 3; k++) begin
            v[k] = int'($urandom_range(31));
            tail += v[k];
            issue(v[k]);
        end
        en_in = 1'b0;
        wait_valid();
        total++; if (acc_out !== 8'(tail) || acc_cnt !== 4'd4)
            $display("FAIL skid_next_batch: got %0d/%0d want %0d/4", acc_out, acc_cnt, tail);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_ovf();
        do_reset();
        acc_ready = 1'b1;
        for (int k = 0; k < 4; k++) issue(31);
        en_in = 1'b0;
        wait_valid();
        total++; if (acc_valid6 !== 1'b1) $display("FAIL ovf6_valid: got %b want 1", acc_valid6); else passed++;
        total++; if (acc_out6 !== 6'd60) $display("FAIL ovf6_acc: got %0d want 60", acc_out6); else passed++;
        total++; if (ovf6 !== 1'b1) $display("FAIL ovf6_flag: got %b want 1", ovf6); else passed++;
        total++; if (acc_out !== 8'd124 || ovf !== 1'b0)
            $display("FAIL ovf8: got %0d/%b want 124/0", acc_out, ovf);
        else passed++;
        @(negedge clk);
        total++; if (ovf6 !== 1'b1) $display("FAIL ovf6_sticky: got %b want 1", ovf6); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        acc_ready = 1'b1;
        issue(8);
        issue(8);
        en_in = 1'b0;
        @(negedge clk);
        total++; if (acc_out !== 8'd16 || acc_cnt !== 4'd2)
            $display("FAIL mid_partial: got %0d/%0d want 16/2", acc_out, acc_cnt);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({acc_out, acc_cnt, acc_valid, stall, ovf, err} !== '0)
            $display("FAIL mid_async_reset: got %0d/%0d/%b%b%b%b want all 0", acc_out, acc_cnt, acc_valid, stall, ovf, err);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) issue(2);
        en_in = 1'b0;
        wait_valid();
        total++; if (acc_out !== 8'd8 || acc_cnt !== 4'd4)
            $display("FAIL mid_next_batch: got %0d/%0d want 8/4", acc_out, acc_cnt);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int exp_q[$];
        int s[32];
        int batches, last_cyc, t;
        do_reset();
        acc_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            t = 0;
            for (int k = 0; k < 4; k++) begin
                s[b * 4 + k] = int'($urandom_range(31));
                t += s[b * 4 + k];
            end
            exp_q.push_back(t);
        end
        batches  = 0;
        last_cyc = -1;
        for (int c = 0; c < 44; c++) begin
            if (acc_valid) begin
                if (exp_q.size() == 0) begin
                    total++; $display("FAIL b2b_extra_batch: got %0d want none", acc_out);
                end else begin
                    t = exp_q.pop_front();
                    total++; if (acc_out !== 8'(t) || acc_cnt !== 4'd4)
                        $display("FAIL b2b_batch: got %0d/%0d want %0d/4", acc_out, acc_cnt, t);
                    else passed++;
                end
                if (last_cyc >= 0) begin
                    total++; if (c - last_cyc != 4) $display("FAIL b2b_period: got %0d want 4", c - last_cyc); else passed++;
                end
                last_cyc = c;
                batches++;
            end
            if (c < 32) begin
                en_in  = 1'b1;
                sum_nx = 5'(s[c]);
            end else begin
                en_in = 1'b0;
            end
            @(negedge clk);
        end
        total++; if (batches != 8) $display("FAIL b2b_count: got %0d want 8", batches); else passed++;
        total++; if (err !== 1'b0) $display("FAIL b2b_err: got %b want 0", err); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        for (int i = 0; i < 3; i++) test_batch(i);
        for (int i = 0; i < 2; i++) test_flush(i);
        test_skid(1'b0);
        test_skid(1'b1);
        test_ovf();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
